// File: rtl/uart_tx_param.sv
// ---------------------------------------------------------------------------
// uart_tx_param
// Parametrised serial transmitter. Divides the system clock down to the bit
// rate internally and sends one frame per accepted word:
//   start (0) | DATA_BITS data, LSB first | optional parity | STOP_BITS stop (1)
//
// Parameters:
//   DATA_BITS    data bits per frame (5..9)
//   CLKS_PER_BIT clk cycles per serial bit (>= 2)
//   PARITY       0 = none, 1 = even, 2 = odd
//   STOP_BITS    stop bits per frame (1..2)
//
// Ports:
//   clk        system clock, all state changes on posedge
//   rst        asynchronous active-high reset
//   tx_data    word to send, sampled only on the accept edge
//   tx_valid   request to send tx_data
//   tx_ready   high when idle and able to accept a word
//   dout       serial line, idles high
//   tx_done    one-cycle pulse in the cycle after a frame completes
//   tx_status  1 = idle, 0 = frame in progress (same as tx_ready)
// ---------------------------------------------------------------------------
module uart_tx_param #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 dout,
    output logic                 tx_done,
    output logic                 tx_status
);

    // Elaboration-time parameter legality checks.
    if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data_bits
        $error("uart_tx_param: DATA_BITS must be 5..9");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_tx_param: CLKS_PER_BIT must be >= 2");
    end
    if ((PARITY < 0) || (PARITY > 2)) begin : g_bad_parity
        $error("uart_tx_param: PARITY must be 0, 1 or 2");
    end
    if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop_bits
        $error("uart_tx_param: STOP_BITS must be 1..2");
    end

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic              HAS_PAR   = (PARITY != 0) ? 1'b1 : 1'b0;
    localparam logic              ODD_PAR   = (PARITY == 2) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Parity bit for a data word: XOR of the data, inverted in odd mode.
    function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
        return (^d) ^ ODD_PAR;
    endfunction

    state_t                 state_q, state_d;
    logic [BAUD_W-1:0]      baud_q, baud_d;
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_q, par_d;
    logic                   dout_q, dout_d;
    logic                   ready_q, ready_d;
    logic                   done_q, done_d;
    logic                   baud_last_s;

    assign baud_last_s = (baud_q == BAUD_LAST);

    // Next-state and next-output logic. dout_d is the line level for the
    // cycle after the edge, so the register always holds the current bit.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        dout_d  = dout_q;
        ready_d = ready_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                baud_d  = '0;
                bit_d   = '0;
                dout_d  = 1'b1;
                ready_d = 1'b1;
                if (tx_valid && ready_q) begin
                    shift_d = tx_data;
                    par_d   = calc_parity(tx_data);
                    state_d = ST_START;
                    ready_d = 1'b0;
                    dout_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_START: begin
                if (baud_last_s) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = ST_DATA;
                    dout_d  = shift_q[0];
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            ST_DATA: begin
                if (baud_last_s) begin
                    baud_d = '0;
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
                        if (HAS_PAR) begin
                            state_d = ST_PARITY;
                            dout_d  = par_q;
                        end else begin
                            state_d = ST_STOP;
                            dout_d  = 1'b1;
                        end
                    end else begin
                        // Shift right so the next data bit sits at [0].
                        bit_d   = bit_q + BIT_W'(1);
                        shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
                        dout_d  = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            ST_PARITY: begin
                if (baud_last_s) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = ST_STOP;
                    dout_d  = 1'b1;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            ST_STOP: begin
                // bit counter is reused to count stop bits.
                if (baud_last_s) begin
                    baud_d = '0;
                    if (bit_q == STOP_LAST) begin
                        bit_d   = '0;
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        ready_d = 1'b1;
                        dout_d  = 1'b1;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                baud_d  = '0;
                bit_d   = '0;
                dout_d  = 1'b1;
                ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers with asynchronous reset to the idle line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            dout_q  <= 1'b1;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            dout_q  <= dout_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign dout      = dout_q;
    assign tx_ready  = ready_q;
    assign tx_status = ready_q;
    assign tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
module tb_uart_tx_param;

    typedef struct packed {
        logic dout;
        logic ready;
        logic done;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] data_r;
    logic [3:0] valid_r;
    logic [3:0] dout_w, ready_w, done_w, status_w;
    logic [1:0] sel;

    int total = 0;
    int bad   = 0;
    int ndone;
    exp_t exp_q[$];

    // Frame configuration of each instance: data bits, parity, stop bits, cpb
    int db_c  [4] = '{8, 8, 8, 7};
    int par_c [4] = '{0, 1, 2, 0};
    int sb_c  [4] = '{1, 1, 1, 2};
    int cpb_c [4] = '{4, 4, 4, 3};

    always #5 clk = ~clk;

    uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) u_a (
        .clk(clk), .rst(rst), .tx_data(data_r[7:0]), .tx_valid(valid_r[0]),
        .tx_ready(ready_w[0]), .dout(dout_w[0]), .tx_done(done_w[0]), .tx_status(status_w[0]));
    uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) u_b (
        .clk(clk), .rst(rst), .tx_data(data_r[7:0]), .tx_valid(valid_r[1]),
        .tx_ready(ready_w[1]), .dout(dout_w[1]), .tx_done(done_w[1]), .tx_status(status_w[1]));
    uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1)) u_c (
        .clk(clk), .rst(rst), .tx_data(data_r[7:0]), .tx_valid(valid_r[2]),
        .tx_ready(ready_w[2]), .dout(dout_w[2]), .tx_done(done_w[2]), .tx_status(status_w[2]));
    uart_tx_param #(.DATA_BITS(7), .CLKS_PER_BIT(3), .PARITY(0), .STOP_BITS(2)) u_d (
        .clk(clk), .rst(rst), .tx_data(data_r[6:0]), .tx_valid(valid_r[3]),
        .tx_ready(ready_w[3]), .dout(dout_w[3]), .tx_done(done_w[3]), .tx_status(status_w[3]));

    task automatic chk(input string tag, input logic obs, input logic exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Push the expected per-cycle line/ready/done values of one frame,
    // followed by its done cycle.
    task automatic push_frame(input int s, input logic [8:0] d);
        logic bits[$];
        logic p;
        bits.push_back(1'b0);
        p = 1'b0;
        for (int i = 0; i < db_c[s]; i++) begin
            bits.push_back(d[i]);
            p = p ^ d[i];
        end
        if (par_c[s] == 1) bits.push_back(p);
        if (par_c[s] == 2) bits.push_back(~p);
        for (int i = 0; i < sb_c[s]; i++) bits.push_back(1'b1);
        foreach (bits[b]) begin
            for (int c = 0; c < cpb_c[s]; c++) exp_q.push_back('{bits[b], 1'b0, 1'b0});
        end
        exp_q.push_back('{1'b1, 1'b1, 1'b1});
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back('{1'b1, 1'b1, 1'b0});
    endtask

    // Called on a negedge: request a frame and record its expectation.
    task automatic kick(input int s, input logic [8:0] d);
        sel        = 2'(s);
        data_r     = d;
        valid_r[s] = 1'b1;
        push_frame(s, d);
    endtask

    // Pop and compare one expectation per cycle (sampled on the negedge).
    task automatic run(input int s, input int pulse_at, input logic hold, input logic [8:0] next_data);
        exp_t e;
        int i;
        i = 0;
        ndone = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            chk($sformatf("i%0d dout c%0d", s, i + 1), dout_w[s], e.dout);
            chk($sformatf("i%0d ready c%0d", s, i + 1), ready_w[s], e.ready);
            chk($sformatf("i%0d status c%0d", s, i + 1), status_w[s], e.ready);
            chk($sformatf("i%0d done c%0d", s, i + 1), done_w[s], e.done);
            if (done_w[s] === 1'b1) ndone++;
            if (i == 0) data_r = next_data;
            if (!hold || exp_q.size() == 0) valid_r[s] = 1'b0;
            if (i == pulse_at) begin
                valid_r[s] = 1'b1;
                data_r     = 9'h1FF;
            end
            i++;
        end
        valid_r[s] = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        data_r  = 9'h000;
        valid_r = 4'b0000;
        sel     = 2'd0;
        #1;
        for (int s = 0; s < 4; s++) begin
            chk($sformatf("rst dout i%0d", s), dout_w[s], 1'b1);
            chk($sformatf("rst ready i%0d", s), ready_w[s], 1'b1);
            chk($sformatf("rst status i%0d", s), status_w[s], 1'b1);
            chk($sformatf("rst done i%0d", s), done_w[s], 1'b0);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Plain 8N1 frame, data changed after accept to prove latching
        kick(0, 9'h0A5);
        run(0, -1, 1'b0, 9'h05A);
        chk_int("done count 0xA5", ndone, 1);

        // Even and odd parity
        kick(1, 9'h007);
        run(1, -1, 1'b0, 9'h000);
        kick(2, 9'h007);
        run(2, -1, 1'b0, 9'h000);

        // 7 data bits, two stop bits, 3 clocks per bit
        kick(3, 9'h055);
        run(3, -1, 1'b0, 9'h02A);

        // Back-to-back with tx_valid held high
        kick(0, 9'h001);
        push_frame(0, 9'h080);
        run(0, -1, 1'b1, 9'h080);
        chk_int("done count b2b", ndone, 2);

        // Request during data phase is ignored
        kick(0, 9'h000);
        push_idle(6);
        run(0, 10, 1'b0, 9'h000);
        chk_int("done count ignored", ndone, 1);

        // Asynchronous reset in cycle 15 of a 0xC3 frame
        data_r     = 9'h0C3;
        valid_r[0] = 1'b1;
        @(negedge clk);
        valid_r[0] = 1'b0;
        repeat (13) @(negedge clk);
        @(posedge clk);
        #1;
        chk("pre-rst dout", dout_w[0], 1'b0);
        chk("pre-rst ready", ready_w[0], 1'b0);
        #1;
        rst = 1'b1;
        #1;
        chk("async rst dout", dout_w[0], 1'b1);
        chk("async rst ready", ready_w[0], 1'b1);
        chk("async rst status", status_w[0], 1'b1);
        chk("async rst done", done_w[0], 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("post-rst done %0d", i), done_w[0], 1'b0);
            chk($sformatf("post-rst dout %0d", i), dout_w[0], 1'b1);
        end
        kick(0, 9'h05A);
        run(0, -1, 1'b0, 9'h0FF);
        chk_int("done count after rst", ndone, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised serial transmitter for the serial_transceiver family. It runs from one system clock and divides down internally to the bit rate, so no separate send clock is needed. Frame format is configurable: data width, parity mode and stop-bit count. A valid/ready handshake accepts bytes, and a one-cycle done pulse marks each completed frame. It feeds the line driver and pairs with the matching parametrised receiver.

Parameters:
DATA_BITS, 8, data bits per frame; legal 5..9.
CLKS_PER_BIT, 16, clk cycles per serial bit; legal >= 2.
PARITY, 0, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, stop bits per frame; legal 1..2.

Ports:
clk  input  1  system clock; all state changes on posedge.
rst  input  1  asynchronous active-high reset.
tx_data  input  DATA_BITS  word to send; sampled only at the accept edge.
tx_valid  input  1  request to send tx_data.
tx_ready  output  1  high when idle and able to accept.
dout  output  1  serial line; idles high.
tx_done  output  1  one-cycle pulse when a frame completes.
tx_status  output  1  1 = idle, 0 = frame in progress; equals tx_ready.

Behaviour:
- Reset: asserting rst forces the following immediately, without waiting for a clock edge: dout=1, tx_ready=1, tx_status=1, tx_done=0, state=IDLE, baud counter=0, bit counter=0.
- Reset mid-frame aborts the frame. dout returns high at once. No tx_done is produced.
- All outputs are registered. dout is never a combinational function of inputs.
- FSM states: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE. PARITY is skipped when PARITY=0.
- Accept: a transfer happens on the posedge where tx_valid=1 and tx_ready=1 (state IDLE).
  - tx_data is latched into the shift register.
  - The state goes to START, and tx_ready/tx_status drop in the next cycle.
- Define cycle 1 as the first cycle after the accept edge.
- Bit timing: every bit holds dout for exactly CLKS_PER_BIT cycles.
  - The baud counter counts 0..CLKS_PER_BIT-1.
  - The bit advances on the edge where the counter equals CLKS_PER_BIT-1; the counter wraps to 0 on that edge.
- START: dout=0.
- DATA: DATA_BITS bits, LSB first.
- PARITY: even mode sends the XOR of the latched data; odd mode sends the inverse of that XOR.
- STOP: dout=1 for STOP_BITS*CLKS_PER_BIT cycles.
- Frame length: N = (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * CLKS_PER_BIT cycles, occupying cycles 1..N.
- End of frame: on the edge ending cycle N, the state returns to IDLE. In cycle N+1, tx_done=1 (exactly one cycle), tx_ready=1 and dout=1.
- Back-to-back: if tx_valid is held high, the next frame is accepted on the edge ending cycle N+1. Result: exactly one idle-high cycle between frames, and the period is N+1.
- tx_valid while busy is ignored. It is not queued and has no effect on dout.
- tx_data changes after the accept edge have no effect on the current frame.
- Bit counter width is clog2(DATA_BITS+1). Baud counter width is clog2(CLKS_PER_BIT). Neither may overflow for any legal parameter set.
- Illegal parameter values must stop elaboration through a generate-time check.

Test Plan:
1. Defaults except CLKS_PER_BIT=4, PARITY=0. Send 0xA5.
   -> dout is 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles (40 cycles).
   -> tx_done high only in cycle 41; tx_ready low in cycles 1..40.
2. PARITY=1, CLKS_PER_BIT=4. Send 0x07.
   -> parity bit = 1 in cycles 37..40; stop bit in cycles 41..44; tx_done in cycle 45.
   Same stimulus with PARITY=2 -> parity bit = 0.
3. STOP_BITS=2, DATA_BITS=7, CLKS_PER_BIT=3. Send 0x55.
   -> stop high in cycles 25..30; tx_done in cycle 31; total 30 active cycles.
4. tx_valid held high with 0x01 then 0x80, defaults at CLKS_PER_BIT=4.
   -> second start bit begins in cycle 42.
   -> exactly one idle-high cycle between frames; exactly two tx_done pulses.
5. Pulse tx_valid with 0xFF during the data phase of a 0x00 frame.
   -> the 0x00 frame completes unchanged and no second frame starts.
6. Assert rst asynchronously in cycle 15 of a frame.
   -> dout=1 and tx_ready=1 before the next clk edge; no tx_done.
   -> a frame requested after rst is released is sent intact.
